// File: rtl/vga_timing_gen.sv
// vga_timing_gen: single-clock VGA raster timing with pixel-tick enable, colour bars and registered outputs
module vga_timing_gen #(
    parameter int   CLK_DIV   = 4,
    parameter int   CNT_W     = 10,
    parameter int   COLOR_W   = 2,
    parameter int   H_VIS     = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_VIS     = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic SYNC_POL  = 1'b0,
    parameter int   BAR_SHIFT = 6
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [3*COLOR_W-1:0] rgbContent,
    input  logic                 patternEn,
    output logic [CNT_W-1:0]     horCnt,
    output logic [CNT_W-1:0]     verCnt,
    output logic                 pixTick,
    output logic [COLOR_W-1:0]   vgaRed,
    output logic [COLOR_W-1:0]   vgaGreen,
    output logic [COLOR_W-1:0]   vgaBlue,
    output logic                 hSync,
    output logic                 vSync,
    output logic                 sActive,
    output logic                 lineStart,
    output logic                 frameStart
);
    localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SYNC);

    logic [DIV_W-1:0]   div, divNext;
    logic               act, hsAct, vsAct;
    logic [2:0]         bar;
    logic [COLOR_W-1:0] srcR, srcG, srcB;

    always_comb begin
        divNext = div == DIV_LAST ? '0 : div + 1'b1;
        act     = horCnt < H_VIS_C && verCnt < V_VIS_C;
        hsAct   = horCnt >= HS_BEG && horCnt < HS_END;
        vsAct   = verCnt >= VS_BEG && verCnt < VS_END;
        bar     = horCnt[BAR_SHIFT+2:BAR_SHIFT];
        srcR    = patternEn ? {COLOR_W{bar[0]}} : rgbContent[COLOR_W-1:0];
        srcG    = patternEn ? {COLOR_W{bar[1]}} : rgbContent[2*COLOR_W-1:COLOR_W];
        srcB    = patternEn ? {COLOR_W{bar[2]}} : rgbContent[3*COLOR_W-1:2*COLOR_W];
    end

    // pixTick is registered so it is 0 in reset even when CLK_DIV=1
    always_ff @(posedge clk) begin
        if (!resetN) begin
            div        <= '0;
            pixTick    <= 1'b0;
            horCnt     <= '0;
            verCnt     <= '0;
            vgaRed     <= '0;
            vgaGreen   <= '0;
            vgaBlue    <= '0;
            sActive    <= 1'b0;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
            hSync      <= ~SYNC_POL;
            vSync      <= ~SYNC_POL;
        end else begin
            div        <= divNext;
            pixTick    <= divNext == DIV_LAST;
            lineStart  <= pixTick && horCnt == '0;
            frameStart <= pixTick && horCnt == '0 && verCnt == '0;
            if (pixTick) begin
                horCnt   <= horCnt == H_LAST ? '0 : horCnt + 1'b1;
                if (horCnt == H_LAST)
                    verCnt <= verCnt == V_LAST ? '0 : verCnt + 1'b1;
                sActive  <= act;
                hSync    <= hsAct ? SYNC_POL : ~SYNC_POL;
                vSync    <= vsAct ? SYNC_POL : ~SYNC_POL;
                vgaRed   <= act ? srcR : '0;
                vgaGreen <= act ? srcG : '0;
                vgaBlue  <= act ? srcB : '0;
            end
        end
    end
endmodule
